register_writeback_queue: RTL
=============================

// Module: register_writeback_queue
// PURPOSE
//   Write-side initiator for the register file: collects results from the ALU and
//   memory producers over valid/ready, buffers them in an in-order queue, and drains
//   one write per cycle onto the register file write port (writeIndex/writeValue).
//   Also answers two combinational forwarding queries, so decode sees values that are
//   queued but not yet written. Sits between execute/memory stages and the register file.
// PARAMETERS
//   REGISTER_NUMBER_LOG  5   register index width (32 registers)
//   DATA_WIDTH           32  result width
//   QUEUE_DEPTH          4   queue entries; power of two, >= 2
// PORTS
//   clk          in   1    sole clock, rising edge
//   reset        in   1    synchronous, active-high
//   memValid     in   1    memory-stage result offered
//   memIndex     in   RNL  destination register of memory result
//   memValue     in   DW   memory result value
//   memReady     out  1    memory result accepted this cycle when memValid=1
//   aluValid     in   1    ALU result offered
//   aluIndex     in   RNL  destination register of ALU result
//   aluValue     in   DW   ALU result value
//   aluReady     out  1    ALU result accepted this cycle when aluValid=1
//   writeEnable  out  1    registered; 1 for exactly one cycle per drained entry
//   writeIndex   out  RNL  registered register-file write index
//   writeValue   out  DW   registered register-file write value
//   queryIndexA  in   RNL  forwarding lookup A
//   queryHitA    out  1    A matches a queued entry
//   queryValueA  out  DW   value of youngest matching entry (0 when no hit)
//   queryIndexB  in   RNL  forwarding lookup B
//   queryHitB    out  1    as A
//   queryValueB  out  DW   as A
//   count        out  log2(QUEUE_DEPTH)+1  occupied entries, registered
// BEHAVIOUR
//   - Reset (sync, rising clk with reset=1): count=0, head/tail pointers=0,
//     writeEnable=0, writeIndex=0, writeValue=0. Queue contents are don't-care.
//     Reset beats every same-cycle enqueue/dequeue; in-flight entries are discarded.
//   - Ready is combinational from count (start-of-cycle) and memValid only, never
//     from the same-cycle dequeue:
//       memReady = (count < QUEUE_DEPTH)
//       aluReady = memValid ? (count < QUEUE_DEPTH-1) : (count < QUEUE_DEPTH)
//   - Handshake: a transfer occurs when valid & ready at a rising clk. Producers hold
//     index/value stable while valid=1 and ready=0.
//   - Both accepted in one cycle: the memory entry is enqueued first (older), then ALU.
//   - Index 0 filter: an accepted transfer with index 0 handshakes normally but is
//     not enqueued, because $0 is never written. It does not change count.
//   - Drain: each cycle with count>0, the head entry is dequeued. Next cycle
//     writeEnable=1, writeIndex/writeValue = that entry. Latency is 1 cycle from
//     enqueue to writeEnable when the queue was empty. With count=0, next
//     writeEnable=0 and writeIndex/writeValue hold their previous values.
//   - Order: writes leave strictly in enqueue order. No merging of same-index entries.
//   - count_next = count + enq_count - deq. Pointers wrap modulo QUEUE_DEPTH.
//     A same-cycle enqueue and dequeue when count=QUEUE_DEPTH is impossible by the
//     ready rules.
//   - Forwarding: combinational over queued entries only; the entry already on the
//     write port is excluded. Youngest match wins. Query index 0 never hits.
//   - No state machine beyond pointers/count. The queue is never in an illegal state.
// TESTING
//   1. Reset, then memValid=1 idx=3 val=0x11 for 1 cycle -> memReady=1; next cycle
//      writeEnable=1, writeIndex=3, writeValue=0x11; following cycle writeEnable=0.
//   2. Both valid in one cycle: mem(5,0xA), alu(5,0xB), count=0 -> both ready;
//      writes (5,0xA) then (5,0xB). While both are queued, queryIndexA=5 ->
//      hit, value 0xB.
//   3. aluValid=1 idx=0 val=0xFF -> aluReady=1, count stays 0, no writeEnable,
//      queryIndexA=0 -> queryHitA=0.
//   4. Fill: count=3, mem+alu valid -> memReady=1, aluReady=0; ALU entry is
//      accepted the next cycle after one drain. Total 5 writes, in order.
//   5. count=4 -> memReady=0, aluReady=0; one cycle later count=3 and memReady=1.
//   6. reset asserted with count=3 mid-drain -> next cycle count=0, writeEnable=0,
//      queries miss, no further writes.

Source files
------------

// File: rtl/register_writeback_queue.sv
// In-order write-back queue: accepts memory and ALU results over valid/ready,
// drains one register-file write per cycle and forwards queued values to decode.
module register_writeback_queue #(
  parameter int REGISTER_NUMBER_LOG = 5,
  parameter int DATA_WIDTH          = 32,
  parameter int QUEUE_DEPTH         = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           memValid,
  input  logic [REGISTER_NUMBER_LOG-1:0] memIndex,
  input  logic [DATA_WIDTH-1:0]          memValue,
  output logic                           memReady,
  input  logic                           aluValid,
  input  logic [REGISTER_NUMBER_LOG-1:0] aluIndex,
  input  logic [DATA_WIDTH-1:0]          aluValue,
  output logic                           aluReady,
  output logic                           writeEnable,
  output logic [REGISTER_NUMBER_LOG-1:0] writeIndex,
  output logic [DATA_WIDTH-1:0]          writeValue,
  input  logic [REGISTER_NUMBER_LOG-1:0] queryIndexA,
  output logic                           queryHitA,
  output logic [DATA_WIDTH-1:0]          queryValueA,
  input  logic [REGISTER_NUMBER_LOG-1:0] queryIndexB,
  output logic                           queryHitB,
  output logic [DATA_WIDTH-1:0]          queryValueB,
  output logic [$clog2(QUEUE_DEPTH):0]   count
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;

  logic [REGISTER_NUMBER_LOG-1:0] idx_q [QUEUE_DEPTH];
  logic [DATA_WIDTH-1:0]          val_q [QUEUE_DEPTH];

  logic [CW-1:0]                  count_q, count_d;
  logic [PW-1:0]                  head_q, head_d;
  logic [PW-1:0]                  tail_q, tail_d;
  logic [PW-1:0]                  alu_slot;
  logic                           we_q, we_d;
  logic [REGISTER_NUMBER_LOG-1:0] wi_q, wi_d;
  logic [DATA_WIDTH-1:0]          wv_q, wv_d;
  logic                           mem_enq, alu_enq, deq;

  // Ready depends only on start-of-cycle occupancy, so a full queue never
  // relies on the same-cycle drain to make room.
  assign memReady = (count_q < CW'(QUEUE_DEPTH));
  assign aluReady = memValid ? (count_q < CW'(QUEUE_DEPTH - 1))
                             : (count_q < CW'(QUEUE_DEPTH));

  assign mem_enq  = memValid && memReady && (memIndex != '0);
  assign alu_enq  = aluValid && aluReady && (aluIndex != '0);
  assign deq      = (count_q != '0);
  assign alu_slot = tail_q + PW'(mem_enq);

  always_comb begin
    count_d = count_q + CW'(mem_enq) + CW'(alu_enq) - CW'(deq);
    tail_d  = tail_q + PW'(mem_enq) + PW'(alu_enq);
    head_d  = head_q + PW'(deq);
    we_d    = deq;
    wi_d    = wi_q;
    wv_d    = wv_q;
    if (deq) begin
      wi_d = idx_q[head_q];
      wv_d = val_q[head_q];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      we_q    <= 1'b0;
      wi_q    <= '0;
      wv_q    <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      we_q    <= we_d;
      wi_q    <= wi_d;
      wv_q    <= wv_d;
    end
  end

  // Entry storage needs no reset: only slots inside [head, head+count) are read.
  always_ff @(posedge clk) begin
    if (mem_enq) begin
      idx_q[tail_q] <= memIndex;
      val_q[tail_q] <= memValue;
    end
    if (alu_enq) begin
      idx_q[alu_slot] <= aluIndex;
      val_q[alu_slot] <= aluValue;
    end
  end

  // Scan oldest to youngest so the last match (youngest) wins.
  always_comb begin
    queryHitA   = 1'b0;
    queryValueA = '0;
    for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
      if ((CW'(i) < count_q) && (queryIndexA != '0) &&
          (idx_q[head_q + PW'(i)] == queryIndexA)) begin
        queryHitA   = 1'b1;
        queryValueA = val_q[head_q + PW'(i)];
      end
    end
  end

  always_comb begin
    queryHitB   = 1'b0;
    queryValueB = '0;
    for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
      if ((CW'(i) < count_q) && (queryIndexB != '0) &&
          (idx_q[head_q + PW'(i)] == queryIndexB)) begin
        queryHitB   = 1'b1;
        queryValueB = val_q[head_q + PW'(i)];
      end
    end
  end

  assign writeEnable = we_q;
  assign writeIndex  = wi_q;
  assign writeValue  = wv_q;
  assign count       = count_q;

endmodule
